rr_arbiter4: RTL and testbench
==============================

RR_ARBITER4 -- requirements
Module: rr_arbiter4

Interface
REQ-001 Parameter MAX_HOLD, default 8, range 2..15: maximum consecutive cycles one requester may hold a grant.
REQ-002 Ports: one clock; reset is synchronous and active-high.
REQ-003 CLK  input  1  rising-edge clock for all state.
REQ-004 Reset  input  1  synchronous, active-high reset.
REQ-005 req  input  4  request lines; bit i = requester i wants the shared resource.
REQ-006 done  input  4  release strobes; bit i = requester i finished; ignored unless i is current owner.
REQ-007 grant  output  4  one-hot grant, or 4'b0000 when idle; registered.
REQ-008 grant_idx  output  2  binary index of current owner; 0 when idle.
REQ-009 busy  output  1  high while a grant is held.
REQ-010 timeout  output  1  one-cycle pulse when a grant is revoked by MAX_HOLD expiry.

Function
REQ-011 FSM has exactly two states: IDLE (no owner) and BUSY (owner = grant_idx).
REQ-012 Priority pointer ptr (2 bits): search order is ptr, ptr+1, ptr+2, ptr+3 mod 4; first asserted req wins.
REQ-013 IDLE: if req != 0 at a rising edge, next cycle state = BUSY, grant_idx = winner, hold count = 0; otherwise remain IDLE with all outputs 0.
REQ-014 Grant latency: grant visible exactly 1 cycle after the edge at which req is sampled; no combinational path req -> grant.
REQ-015 grant SHALL equal the 2-to-4 decode of grant_idx whenever busy = 1: idx 0->0001, 1->0010, 2->0100, 3->1000.
REQ-016 BUSY: hold count increments by 1 each cycle; saturates, never wraps.
REQ-017 Release condition (any of): done[grant_idx] = 1; req[grant_idx] = 0; hold count = MAX_HOLD-1.
REQ-018 On release: ptr <= grant_idx+1 mod 4; arbitration per REQ-012 over current req using the new ptr, in the same cycle.
REQ-019 Release with a winner: stay BUSY, new owner next cycle, count cleared (back-to-back handoff, no idle bubble).
REQ-020 Release with no req: go to IDLE; grant = 0, busy = 0 next cycle.
REQ-021 Former owner may be regranted only if it is the sole requester (lowest priority after release).
REQ-022 timeout = 1 for one cycle, the cycle after release, only when release caused solely by count expiry (done and req of owner not the cause).
REQ-023 done bits of non-owners SHALL have no effect; simultaneous done and expiry counts as normal release, timeout = 0.
REQ-024 ptr changes only on release; never on initial IDLE grant.

Reset
REQ-025 Reset = 1 at a rising edge: state IDLE, ptr 0, count 0, grant 0000, grant_idx 0, busy 0, timeout 0.
REQ-026 Reset dominates every other input, including mid-grant; first grant after reset follows REQ-013 with ptr 0.

Structure
REQ-027 Shared package holds state encoding (IDLE, BUSY), requester count 4, and MAX_HOLD default.
REQ-028 grant generated by instantiating the team's existing Decode24 module driven by grant_idx, gated by busy; no other sub-module.
REQ-029 Priority search implemented as a single combinational function of req and ptr; all outputs registered.

Verification
REQ-030 Reset, req=0000 for 5 cycles -> grant 0000, busy 0, grant_idx 0, timeout 0 each cycle.
REQ-031 After reset, req=0110 -> next cycle grant 0010, idx 1; done=0010 -> next cycle grant 0100, idx 2 (handoff, no bubble).
REQ-032 req=1111 held constantly, done pulsed on owner every 3 cycles -> grant order 0001,0010,0100,1000,0001 (wrap-around).
REQ-033 MAX_HOLD=8, req=0001 plus 1000, no done -> owner 0 holds 8 cycles, then grant 1000, timeout pulse 1 cycle.
REQ-034 Sole requester req=0100 with done each grant -> regranted 0100 every cycle after release; timeout stays 0.
REQ-035 Reset asserted while busy with idx 3 -> next cycle grant 0000, busy 0; release reset with req=1010 -> grant 0010 (ptr 0).

Source files
------------

// File: rtl/rr_arbiter4_pkg.sv
// Shared definitions for the 4-way round-robin arbiter: FSM encoding,
// sizing constants and the rotating-priority search.
package rr_arbiter4_pkg;

  localparam int NUM_REQ      = 4;
  localparam int MAX_HOLD_DEF = 8;
  localparam int CNT_W        = 4;

  typedef enum logic {
    IDLE = 1'b0,
    BUSY = 1'b1
  } state_e;

  typedef struct packed {
    logic       found;
    logic [1:0] idx;
  } pick_t;

  // Walk from ptr upward (mod 4); iterating high-to-low lets the nearest hit win.
  function automatic pick_t rr_pick(input logic [NUM_REQ-1:0] req, input logic [1:0] ptr);
    pick_t      res;
    logic [1:0] cand;
    res = '0;
    for (int k = NUM_REQ - 1; k >= 0; k--) begin
      cand = ptr + 2'(k);
      if (req[cand]) begin
        res.found = 1'b1;
        res.idx   = cand;
      end
    end
    return res;
  endfunction

endpackage

// File: rtl/rr_arbiter4_if.sv
// Requester-side bundle of the arbiter. Handshake: a requester keeps req high
// while it wants the resource; it owns it while grant is high; done releases.
interface rr_arbiter4_if;
  import rr_arbiter4_pkg::*;

  logic [NUM_REQ-1:0] req;
  logic [NUM_REQ-1:0] done;
  logic [NUM_REQ-1:0] grant;
  logic [1:0]         grant_idx;
  logic               busy;
  logic               timeout;

  modport master (output req, done, input grant, grant_idx, busy, timeout);
  modport slave  (input req, done, output grant, grant_idx, busy, timeout);

endinterface

// File: rtl/rr_arbiter4_decode24.sv
// Enabled 2-to-4 one-hot decoder; all zeros when disabled.
module rr_arbiter4_decode24 (
  input  logic [1:0] idx,
  input  logic       en,
  output logic [3:0] dec
);

  always_comb begin
    dec = '0;
    if (en) dec[idx] = 1'b1;
  end

endmodule

// File: rtl/rr_arbiter4.sv
// Four-requester round-robin arbiter with a bounded hold time per grant.
// All state is registered; grant is a decode of the registered owner index.
module rr_arbiter4
  import rr_arbiter4_pkg::*;
#(
  parameter int MAX_HOLD = MAX_HOLD_DEF
) (
  input  logic          clk,
  input  logic          rst,
  rr_arbiter4_if.slave  bus,
  output state_e        dbg_state
);

  state_e            state_q, state_d;
  logic [1:0]        ptr_q, ptr_d;
  logic [1:0]        idx_q, idx_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              to_q, to_d;

  pick_t             pick;
  logic [1:0]        search_ptr;
  logic              owner_done;
  logic              owner_req;
  logic              expired;
  logic              release_c;

  always_comb begin
    state_d    = state_q;
    ptr_d      = ptr_q;
    idx_d      = idx_q;
    cnt_d      = cnt_q;
    to_d       = 1'b0;
    owner_done = bus.done[idx_q];
    owner_req  = bus.req[idx_q];
    expired    = (cnt_q == CNT_W'(MAX_HOLD - 1));
    release_c  = (state_q == BUSY) && (owner_done || !owner_req || expired);
    // On release the search already uses the advanced pointer this cycle.
    search_ptr = release_c ? (idx_q + 2'd1) : ptr_q;
    pick       = rr_pick(bus.req, search_ptr);

    case (state_q)
      IDLE: begin
        if (pick.found) begin
          state_d = BUSY;
          idx_d   = pick.idx;
          cnt_d   = '0;
        end
      end
      BUSY: begin
        if (release_c) begin
          ptr_d = search_ptr;
          to_d  = expired && owner_req && !owner_done;
          cnt_d = '0;
          if (pick.found) begin
            idx_d = pick.idx;
          end else begin
            state_d = IDLE;
            idx_d   = '0;
          end
        end else if (cnt_q != '1) begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      ptr_q   <= '0;
      idx_q   <= '0;
      cnt_q   <= '0;
      to_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      idx_q   <= idx_d;
      cnt_q   <= cnt_d;
      to_q    <= to_d;
    end
  end

  rr_arbiter4_decode24 u_decode (
    .idx (idx_q),
    .en  (state_q == BUSY),
    .dec (bus.grant)
  );

  assign bus.grant_idx = idx_q;
  assign bus.busy      = (state_q == BUSY);
  assign bus.timeout   = to_q;
  assign dbg_state     = state_q;

endmodule

// File: tb/tb_rr_arbiter4.sv
// Bench for rr_arbiter4: vector table, directed multi-cycle sequences and
// random traffic compared against an owner/pointer reference model.
module tb_rr_arbiter4;
  import rr_arbiter4_pkg::*;

  localparam int MAX_HOLD = 8;

  logic   clk = 1'b0;
  logic   rst;
  state_e dbg_state;

  rr_arbiter4_if bus ();

  rr_arbiter4 #(.MAX_HOLD(MAX_HOLD)) dut (
    .clk       (clk),
    .rst       (rst),
    .bus       (bus),
    .dbg_state (dbg_state)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Packed view: {grant[3:0], grant_idx[1:0], busy, timeout}
  logic [7:0] act;
  logic [7:0] m_exp;
  logic [7:0] exp_q[$];

  int   m_owner = -1;
  int   m_ptr   = 0;
  int   m_held  = 0;
  logic m_to    = 1'b0;

  function automatic int m_pick(input logic [3:0] r, input int p);
    for (int k = 0; k < 4; k++) begin
      if (r[(p + k) % 4]) return (p + k) % 4;
    end
    return -1;
  endfunction

  // m_held counts the cycles the current owner has already been visible.
  task automatic model_step(input logic [3:0] r, input logic [3:0] d, input logic rs);
    int w;
    logic [3:0] g;
    if (rs) begin
      m_owner = -1; m_ptr = 0; m_held = 0; m_to = 1'b0;
    end else begin
      m_to = 1'b0;
      if (m_owner < 0) begin
        w = m_pick(r, m_ptr);
        if (w >= 0) begin m_owner = w; m_held = 1; end
      end else if (d[m_owner] || !r[m_owner] || m_held >= MAX_HOLD) begin
        m_to    = !d[m_owner] && r[m_owner];
        m_ptr   = (m_owner + 1) % 4;
        w       = m_pick(r, m_ptr);
        m_owner = w;
        m_held  = (w >= 0) ? 1 : 0;
      end else begin
        m_held++;
      end
    end
    g = (m_owner >= 0) ? (4'b0001 << m_owner) : 4'b0000;
    exp_q.push_back({g, (m_owner >= 0) ? 2'(m_owner) : 2'd0, m_owner >= 0, m_to});
  endtask

  task automatic cycle(input logic [3:0] r, input logic [3:0] d, input logic rs);
    bus.req  = r;
    bus.done = d;
    rst      = rs;
    @(posedge clk);
    model_step(r, d, rs);
    #1;
    act   = {bus.grant, bus.grant_idx, bus.busy, bus.timeout};
    m_exp = exp_q.pop_front();
  endtask

  task automatic chk(input string name, input logic [7:0] a, input logic [7:0] e);
    checks++;
    if (a !== e) begin
      errors++;
      $display("FAIL %s: got g/idx/busy/to=%b required %b at %0t", name, a, e, $time);
    end
  endtask

  typedef struct {
    logic       rs;
    logic [3:0] req;
    logic [3:0] done;
    logic [7:0] exp;
  } vec_t;

  vec_t       vecs[14];
  logic [3:0] r_prev;
  logic [3:0] g;

  initial begin
    bus.req  = '0;
    bus.done = '0;
    rst      = 1'b1;

    vecs[0]  = '{1'b1, 4'b0000, 4'b0000, 8'b0000_00_0_0};
    vecs[1]  = '{1'b0, 4'b0000, 4'b0000, 8'b0000_00_0_0};
    vecs[2]  = '{1'b0, 4'b0000, 4'b0000, 8'b0000_00_0_0};
    vecs[3]  = '{1'b0, 4'b0000, 4'b0000, 8'b0000_00_0_0};
    vecs[4]  = '{1'b0, 4'b0000, 4'b0000, 8'b0000_00_0_0};
    vecs[5]  = '{1'b0, 4'b0000, 4'b0000, 8'b0000_00_0_0};
    vecs[6]  = '{1'b0, 4'b0110, 4'b0000, 8'b0010_01_1_0};
    vecs[7]  = '{1'b0, 4'b0110, 4'b0010, 8'b0100_10_1_0};
    vecs[8]  = '{1'b0, 4'b0110, 4'b0100, 8'b0010_01_1_0};
    vecs[9]  = '{1'b0, 4'b0000, 4'b0000, 8'b0000_00_0_0};
    vecs[10] = '{1'b0, 4'b1000, 4'b0000, 8'b1000_11_1_0};
    vecs[11] = '{1'b1, 4'b1000, 4'b0000, 8'b0000_00_0_0};
    vecs[12] = '{1'b0, 4'b1010, 4'b0000, 8'b0010_01_1_0};
    vecs[13] = '{1'b0, 4'b0000, 4'b0000, 8'b0000_00_0_0};

    for (int i = 0; i < 14; i++) begin
      cycle(vecs[i].req, vecs[i].done, vecs[i].rs);
      chk($sformatf("vec%0d", i), act, vecs[i].exp);
    end

    // All four requesting, owner releases every third cycle: full rotation.
    cycle(4'b0000, 4'b0000, 1'b1);
    chk("rot_reset", act, 8'b0000_00_0_0);
    cycle(4'b1111, 4'b0000, 1'b0);
    chk("rot_first", act, 8'b0001_00_1_0);
    for (int o = 0; o < 5; o++) begin
      g = 4'b0001 << (o % 4);
      cycle(4'b1111, 4'b0000, 1'b0);
      chk($sformatf("rot_hold%0d_a", o), act, {g, 2'(o % 4), 2'b10});
      cycle(4'b1111, 4'b0000, 1'b0);
      chk($sformatf("rot_hold%0d_b", o), act, {g, 2'(o % 4), 2'b10});
      cycle(4'b1111, g, 1'b0);
      g = 4'b0001 << ((o + 1) % 4);
      chk($sformatf("rot_next%0d", o), act, {g, 2'((o + 1) % 4), 2'b10});
    end

    // Hold expiry with a competing requester.
    cycle(4'b0000, 4'b0000, 1'b1);
    cycle(4'b1001, 4'b0000, 1'b0);
    chk("exp_first", act, 8'b0001_00_1_0);
    for (int i = 2; i <= MAX_HOLD; i++) begin
      cycle(4'b1001, 4'b0000, 1'b0);
      chk($sformatf("exp_hold%0d", i), act, 8'b0001_00_1_0);
    end
    cycle(4'b1001, 4'b0000, 1'b0);
    chk("exp_handoff", act, 8'b1000_11_1_1);
    cycle(4'b1001, 4'b0000, 1'b0);
    chk("exp_pulse_end", act, 8'b1000_11_1_0);

    // Sole requester: regrant after done, expiry, and done coinciding with expiry.
    cycle(4'b0000, 4'b0000, 1'b1);
    cycle(4'b0100, 4'b0000, 1'b0);
    chk("sole_first", act, 8'b0100_10_1_0);
    for (int i = 0; i < 4; i++) begin
      cycle(4'b0100, 4'b0100, 1'b0);
      chk($sformatf("sole_regrant%0d", i), act, 8'b0100_10_1_0);
    end
    for (int i = 2; i <= MAX_HOLD; i++) begin
      cycle(4'b0100, 4'b1011, 1'b0);
      chk($sformatf("sole_hold%0d", i), act, 8'b0100_10_1_0);
    end
    cycle(4'b0100, 4'b0000, 1'b0);
    chk("sole_expire", act, 8'b0100_10_1_1);
    for (int i = 2; i <= MAX_HOLD; i++) begin
      cycle(4'b0100, 4'b0000, 1'b0);
    end
    cycle(4'b0100, 4'b0100, 1'b0);
    chk("sole_done_at_expiry", act, 8'b0100_10_1_0);

    // Random traffic against the reference model.
    cycle(4'b0000, 4'b0000, 1'b1);
    chk("rand_reset", act, m_exp);
    r_prev = '0;
    for (int i = 0; i < 600; i++) begin
      if ($urandom_range(0, 3) == 0) r_prev = 4'($urandom_range(0, 15));
      cycle(r_prev,
            ($urandom_range(0, 9) == 0) ? 4'($urandom_range(1, 15)) : 4'b0000,
            $urandom_range(0, 80) == 0);
      chk("rand", act, m_exp);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
